// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage of a 5-stage RV32I pipeline. Owns the program
// counter and the IF/ID pipeline register. Instruction memory is an external
// combinational ROM: imem_addr goes out and imem_rdata comes back in the same
// cycle.
//
// Update priority on each rising edge:
//   rst > branch_taken (redirect + bubble) > stall (hold) > normal advance
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   rst            synchronous, active-high reset
//   stall          load-use stall from the hazard unit; holds PC and IF/ID
//   branch_taken   EX resolved a taken branch/jump; redirect and flush IF/ID
//   branch_target  redirect address from EX (low two bits ignored)
//   imem_addr      instruction-memory address (= current PC)
//   imem_rdata     instruction at imem_addr, same cycle
//   IF_ID_pc       PC of the instruction held in IF/ID
//   IF_ID_pc4      IF_ID_pc + 4
//   IF_ID_inst     instruction held in IF/ID
//   IF_ID_valid    1 = real instruction, 0 = bubble
//   IF_ID_rs1      IF_ID_inst[19:15], to hazard unit
//   IF_ID_rs2      IF_ID_inst[24:20], to hazard unit
//
// Optional feature (macro FETCH_PERF_CNT_EN):
//   perf_stall_cycles  edges with stall=1 and branch_taken=0 (saturating)
//   perf_flush_count   edges with branch_taken=1 (saturating)
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter int unsigned       XLEN       = 32,
    parameter logic [XLEN-1:0]   RESET_PC   = 32'h0000_0000,
    parameter logic [XLEN-1:0]   NOP_INST   = 32'h0000_0013,
    parameter int unsigned       REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  branch_taken,
    input  logic [XLEN-1:0]       branch_target,
    output logic [XLEN-1:0]       imem_addr,
    input  logic [XLEN-1:0]       imem_rdata,
    output logic [XLEN-1:0]       IF_ID_pc,
    output logic [XLEN-1:0]       IF_ID_pc4,
    output logic [XLEN-1:0]       IF_ID_inst,
    output logic                  IF_ID_valid,
    output logic [REG_ADDR_W-1:0] IF_ID_rs1,
    output logic [REG_ADDR_W-1:0] IF_ID_rs2
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]           perf_stall_cycles,
    output logic [31:0]           perf_flush_count
`endif
);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] redirect_pc;

    // Wraps modulo 2^XLEN; no overflow flag is produced.
    assign pc_plus4    = pc + XLEN'(4);
    // Targets are word-aligned by dropping the low two bits; no misalign trap.
    assign redirect_pc = {branch_target[XLEN-1:2], 2'b00};

    assign imem_addr = pc;

    // Hazard-unit fields are slices of the registered instruction, so a
    // stalled IF/ID keeps presenting the same rs1/rs2.
    assign IF_ID_rs1 = IF_ID_inst[15 +: REG_ADDR_W];
    assign IF_ID_rs2 = IF_ID_inst[20 +: REG_ADDR_W];

    // NOTE: state is written with non-blocking assignments so every register
    // samples the pre-edge values of the others; blocking here would let pc's
    // new value leak into IF_ID_pc within the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            IF_ID_pc    <= '0;
            IF_ID_pc4   <= '0;
            IF_ID_inst  <= NOP_INST;
            IF_ID_valid <= 1'b0;
        end else if (branch_taken) begin
            // Flush: the wrong-path instruction becomes a bubble. IF_ID_pc and
            // IF_ID_pc4 keep their old values since nothing consumes them
            // while valid=0.
            pc          <= redirect_pc;
            IF_ID_inst  <= NOP_INST;
            IF_ID_valid <= 1'b0;
        end else if (!stall) begin
            pc          <= pc_plus4;
            IF_ID_pc    <= pc;
            IF_ID_pc4   <= pc_plus4;
            IF_ID_inst  <= imem_rdata;
            IF_ID_valid <= 1'b1;
        end
        // stall=1, branch_taken=0: every register holds.
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cycles <= '0;
            perf_flush_count  <= '0;
        end else begin
            // Counters saturate at all-ones rather than wrapping.
            if (branch_taken) begin
                if (perf_flush_count != '1) begin
                    perf_flush_count <= perf_flush_count + 32'd1;
                end
            end else if (stall) begin
                if (perf_stall_cycles != '1) begin
                    perf_stall_cycles <= perf_stall_cycles + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline: owns the PC register and the IF/ID pipeline register.
- Consumes the load-use `stall` from the data-hazard unit and the branch redirect from EX.
- Feeds ID with PC, PC+4 and instruction, and feeds the hazard unit with the IF/ID rs1/rs2 fields.
- Instruction memory is an external combinational ROM: address out, data back in the same cycle.

Parameters:
- XLEN, 32, PC/instruction width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0) placed in IF/ID on reset/flush.
- REG_ADDR_W, 5, register-address field width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  load-use stall from hazard unit; hold PC and IF/ID.
- branch_taken  input  1  EX resolved a taken branch/jump; redirect and flush.
- branch_target  input  XLEN  redirect address from EX.
- imem_addr  output  XLEN  instruction-memory address (= current PC).
- imem_rdata  input  XLEN  instruction at imem_addr, same cycle.
- IF_ID_pc  output  XLEN  PC of instruction in IF/ID.
- IF_ID_pc4  output  XLEN  IF_ID_pc + 4.
- IF_ID_inst  output  XLEN  instruction in IF/ID.
- IF_ID_valid  output  1  IF/ID holds a real instruction (0 = bubble).
- IF_ID_rs1  output  REG_ADDR_W  IF_ID_inst[19:15], to hazard unit.
- IF_ID_rs2  output  REG_ADDR_W  IF_ID_inst[24:20], to hazard unit.

Behaviour:
- State: pc, and IF/ID {pc, pc4, inst, valid}.
- imem_addr = pc, combinational.
- IF_ID_rs1/IF_ID_rs2 are combinational slices of the IF_ID_inst register.
- Reset (rst=1 at edge): pc=RESET_PC; IF_ID_pc=0; IF_ID_pc4=0; IF_ID_inst=NOP_INST; IF_ID_valid=0. Reset overrides every other input. Reset asserted mid-operation discards all in-flight state in one cycle.
- Update priority per edge (rst=0): branch_taken > stall > normal advance.
- branch_taken=1:
  - pc <= {branch_target[XLEN-1:2],2'b00}; low two bits are forced to zero, no misalign trap.
  - IF/ID <= bubble: inst=NOP_INST, valid=0, pc/pc4 hold their previous values.
  - This wins even when stall=1 in the same cycle.
- stall=1, branch_taken=0: pc holds; all IF/ID fields hold. The hazard unit keeps re-seeing the same rs1/rs2.
- Normal advance: pc <= pc+4; IF_ID_pc <= pc; IF_ID_pc4 <= pc+4; IF_ID_inst <= imem_rdata; IF_ID_valid <= 1.
- Arithmetic: pc+4 is modulo 2^XLEN; 32'hFFFF_FFFC advances to 32'h0000_0000 with no flag.
- Latency:
  - The instruction at PC p appears on IF_ID_inst one edge after pc=p, given no stall or flush.
  - After a redirect, the target instruction is in IF/ID two edges after branch_taken is sampled; exactly one bubble is seen by ID.
- First fetch: the edge after rst deasserts latches the RESET_PC instruction with valid=1.
- Stall held N cycles: exactly N edges with no PC change; advance resumes the cycle after stall falls.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_stall_cycles (32) and perf_flush_count (32).
  - perf_stall_cycles increments on each edge with stall=1 and branch_taken=0.
  - perf_flush_count increments on each edge with branch_taken=1.
  - Both saturate at 32'hFFFF_FFFF and clear to 0 on rst.
- Undefined: counters and both ports are absent; behaviour is otherwise identical.

Test Plan:
- Reset then free-run with imem returning addr-derived words.
  - After rst: pc=0, IF_ID_inst=32'h13, valid=0.
  - Next edges: IF_ID_pc=0,4,8 with matching inst, valid=1, pc4=pc+4.
- Load-use stall: assert stall for 2 cycles while IF_ID_pc=8.
  - pc stays 12 and IF_ID_pc/inst/rs1/rs2 unchanged for 2 edges.
  - Next edge: IF_ID_pc=12.
- Redirect: branch_taken=1, branch_target=32'h0000_0103 while pc=20.
  - Next edge: pc=32'h100, IF_ID_inst=32'h13, valid=0.
  - Following edge: IF_ID_pc=32'h100, valid=1.
- Simultaneous stall=1 and branch_taken=1, target 32'h40: branch wins.
  - pc=32'h40, IF/ID bubble.
  - With FETCH_PERF_CNT_EN: flush_count +1, stall_cycles unchanged.
- Wrap: redirect to 32'hFFFF_FFFC, then advance.
  - pc=0.
  - IF_ID_pc=32'hFFFF_FFFC, IF_ID_pc4=0.
- Mid-run reset: assert rst during a stall with IF_ID_valid=1.
  - Next edge: pc=RESET_PC, valid=0, inst=32'h13.
  - With FETCH_PERF_CNT_EN: both counters 0.
